// File: rtl/adder_operand_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : adder_operand_sequencer                                         |
// | Purpose  : Issue/capture stage for a combinational carry-select adder.     |
// |            Accepts an operand pair over valid/ready and drives the adder   |
// |            from registers. After SETTLE_CYCLES edges it captures           |
// |            sum/carry/overflow and presents them on an output valid/ready.  |
// |            Keeps a sticky overflow flag.                                   |
// | Ports    : clk, rst_n (async, active-low)                                  |
// |            in_valid_i/in_ready_o, in_a_i/in_b_i/in_cin_i : operand input   |
// |            add_a_o/add_b_o/add_cin_o                     : to adder        |
// |            add_s_i/add_cout_i/add_ovf_i                  : from adder      |
// |            out_valid_o/out_ready_i, out_sum_o/out_cout_o/out_ovf_o: result |
// |            ovf_sticky_o, clr_sticky_i                    : sticky overflow |
// |            ovf_count_o (only with OVF_COUNT_EN)          : overflow count  |
// | Config   : define OVF_COUNT_EN to add a saturating overflow counter.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module adder_operand_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 2,
   parameter int OVF_CNT_W     = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [WIDTH-1:0]     in_a_i,
   input  logic [WIDTH-1:0]     in_b_i,
   input  logic                 in_cin_i,
   output logic [WIDTH-1:0]     add_a_o,
   output logic [WIDTH-1:0]     add_b_o,
   output logic                 add_cin_o,
   input  logic [WIDTH-1:0]     add_s_i,
   input  logic                 add_cout_i,
   input  logic                 add_ovf_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [WIDTH-1:0]     out_sum_o,
   output logic                 out_cout_o,
   output logic                 out_ovf_o,
   output logic                 ovf_sticky_o,
   input  logic                 clr_sticky_i
`ifdef OVF_COUNT_EN
   ,
   output logic [OVF_CNT_W-1:0] ovf_count_o
`endif
);

   // A one-bit counter is kept even when SETTLE_CYCLES==1 (it is loaded with 0).
   localparam int c_cnt_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [c_cnt_w-1:0] c_settle_init = c_cnt_w'(SETTLE_CYCLES - 1);

   if (SETTLE_CYCLES < 1) begin : g_chk_settle
      $error("SETTLE_CYCLES must be >= 1");
   end
   if (OVF_CNT_W < 1) begin : g_chk_cnt_w
      $error("OVF_CNT_W must be >= 1");
   end

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_HOLD   = 2'd2
   } state_t;

   state_t               state_q;
   logic [c_cnt_w-1:0]   cnt_q;
   logic [WIDTH-1:0]     add_a_q;
   logic [WIDTH-1:0]     add_b_q;
   logic                 add_cin_q;
   logic                 out_valid_q;
   logic [WIDTH-1:0]     out_sum_q;
   logic                 out_cout_q;
   logic                 out_ovf_q;
   logic                 sticky_q;

   logic                 w_accept;
   logic                 w_capture;
   logic                 w_cap_ovf;

   assign w_accept  = in_valid_i && (state_q == ST_IDLE);
   assign w_capture = (state_q == ST_SETTLE) && (cnt_q == '0);
   assign w_cap_ovf = w_capture && add_ovf_i;

`ifdef OVF_COUNT_EN
   localparam logic [OVF_CNT_W-1:0] c_cnt_max = {OVF_CNT_W{1'b1}};
   logic [OVF_CNT_W-1:0] ovf_cnt_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_cout_q  <= 1'b0;
         out_ovf_q   <= 1'b0;
         sticky_q    <= 1'b0;
`ifdef OVF_COUNT_EN
         ovf_cnt_q   <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               // Adder operands are only ever written here; they persist
               // through HOLD and back into IDLE until the next accept.
               if (w_accept) begin
                  add_a_q   <= in_a_i;
                  add_b_q   <= in_b_i;
                  add_cin_q <= in_cin_i;
                  cnt_q     <= c_settle_init;
                  state_q   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (w_capture) begin
                  out_sum_q   <= add_s_i;
                  out_cout_q  <= add_cout_i;
                  out_ovf_q   <= add_ovf_i;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_HOLD;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_HOLD: begin
               // Result data is left in place after the handshake.
               if (out_ready_i) begin
                  out_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase

         // A capture with overflow takes priority over a clear on the same edge.
         if (w_cap_ovf) begin
            sticky_q <= 1'b1;
         end else if (clr_sticky_i) begin
            sticky_q <= 1'b0;
         end

`ifdef OVF_COUNT_EN
         if (clr_sticky_i) begin
            ovf_cnt_q <= w_cap_ovf ? OVF_CNT_W'(1) : '0;
         end else if (w_cap_ovf && (ovf_cnt_q != c_cnt_max)) begin
            ovf_cnt_q <= ovf_cnt_q + 1'b1;
         end
`endif
      end
   end

   assign in_ready_o   = (state_q == ST_IDLE);
   assign add_a_o      = add_a_q;
   assign add_b_o      = add_b_q;
   assign add_cin_o    = add_cin_q;
   assign out_valid_o  = out_valid_q;
   assign out_sum_o    = out_sum_q;
   assign out_cout_o   = out_cout_q;
   assign out_ovf_o    = out_ovf_q;
   assign ovf_sticky_o = sticky_q;
`ifdef OVF_COUNT_EN
   assign ovf_count_o  = ovf_cnt_q;
`endif

endmodule
`default_nettype wire
